// File: rtl/issue_queue_npicker_if.sv
// Handshake bundle for the N-picker issue queue: multi-lane enqueue, age-ordered issue ports,
// flush and occupancy.
interface issue_queue_npicker_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned NPICK = 2,
  parameter int unsigned NENQ  = 2
);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic                    flush;
   logic [NENQ-1:0]         in_valid;
   logic [NENQ*WIDTH-1:0]   in_data;
   logic [NENQ-1:0]         in_ready;
   logic [NPICK-1:0]        out_valid;
   logic [NPICK*WIDTH-1:0]  out_data;
   logic [NPICK-1:0]        out_ready;
   logic [CW-1:0]           count;

   modport master (
      output flush, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, count
   );

   modport slave (
      input  flush, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, count
   );
endinterface

// File: rtl/issue_queue_npicker.sv
// In-order issue queue: circular buffer accepting up to NENQ entries and issuing up to NPICK
// oldest entries per cycle, both under prefix handshake rules.
module issue_queue_npicker #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned NPICK = 2,
  parameter int unsigned NENQ  = 2
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   issue_queue_npicker_if.slave  bus
);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned HW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [HW-1:0]    head_q;
   logic [CW-1:0]    count_q, count_d;
   logic [NENQ-1:0]  acc;
   int unsigned      pops, pushes;

   // Modulo reduction keeps non-power-of-two depths wrapping correctly.
   function automatic logic [HW-1:0] wrap(input int unsigned v);
      return HW'(v % DEPTH);
   endfunction

   always_comb begin
      logic fire_prev;
      logic acc_prev;
      bus.out_valid = '0;
      bus.out_data  = '0;
      bus.in_ready  = '0;
      acc           = '0;
      pops          = 0;
      pushes        = 0;
      fire_prev     = 1'b1;
      acc_prev      = 1'b1;
      for (int unsigned k = 0; k < NPICK; k++) begin
         bus.out_valid[k]              = (32'(count_q) > k) && !bus.flush;
         bus.out_data[k*WIDTH +: WIDTH] = mem_q[wrap(32'(head_q) + k)];
         fire_prev = fire_prev && bus.out_valid[k] && bus.out_ready[k];
         if (fire_prev) pops = pops + 1;
      end
      // Space is judged on start-of-cycle occupancy; same-cycle pops do not free slots.
      for (int unsigned j = 0; j < NENQ; j++) begin
         bus.in_ready[j] = ((DEPTH - 32'(count_q)) > j) && !bus.flush;
         acc_prev = acc_prev && bus.in_valid[j] && bus.in_ready[j];
         acc[j]   = acc_prev;
         if (acc_prev) pushes = pushes + 1;
      end
      count_d   = CW'(32'(count_q) + pushes - pops);
      bus.count = count_q;
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n || bus.flush) begin
         head_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= wrap(32'(head_q) + pops);
         count_q <= count_d;
      end
   end

   always_ff @(posedge sys_clk) begin
      for (int unsigned j = 0; j < NENQ; j++) begin
         if (acc[j]) mem_q[wrap(32'(head_q) + 32'(count_q) + j)] <= bus.in_data[j*WIDTH +: WIDTH];
      end
   end

   a_pop_bound  : assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
                                   pops <= 32'(count_q));
   a_push_bound : assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
                                   pushes <= DEPTH - 32'(count_q));
endmodule

// File: doc/issue_queue_npicker.md
Name: issue_queue_npicker

Overview:
- Parametrised in-order issue queue: up to NENQ entries enqueued and up to NPICK oldest entries issued per cycle.
- Circular buffer of DEPTH entries of WIDTH bits each.
- Issue ports are age-ordered: port k always presents the k-th oldest entry.
- Successor to the fixed 2-picker, 8-bit queue. Adds configurable width/depth/pick count, multi-lane enqueue, flush and an occupancy output. Sits between decode and execution-unit arbitration.

Parameters:
- WIDTH, 8, payload bits per entry.
- DEPTH, 8, queue entries; any integer >= max(NPICK, NENQ), not restricted to powers of two.
- NPICK, 2, issue ports; >= 1.
- NENQ, 2, enqueue lanes; >= 1.
- CW, $clog2(DEPTH+1), occupancy count width (derived, not overridable).

Ports:
- sys_clk  in  1  clock; all state updates on rising edge.
- sys_rst_n  in  1  synchronous active-low reset, sampled on sys_clk rising edge.
- flush  in  1  discard all entries this cycle.
- in_valid  in  NENQ  per-lane enqueue request; lane j = bit j.
- in_data  in  NENQ*WIDTH  lane j payload at [j*WIDTH +: WIDTH].
- in_ready  out  NENQ  lane j may be accepted.
- out_valid  out  NPICK  port k holds the k-th oldest entry.
- out_data  out  NPICK*WIDTH  port k payload at [k*WIDTH +: WIDTH].
- out_ready  in  NPICK  consumer accepts port k.
- count  out  CW  current occupancy (registered state).

Behaviour:
- State: storage array, head index (oldest entry), count. Indices wrap modulo DEPTH, including non-power-of-two DEPTH.
- Reset (sys_rst_n=0 at an edge): head=0, count=0.
  - After reset: out_valid=0, in_ready=all 1s, count=0.
  - Storage contents are not reset; out_data is don't-care while out_valid=0.
  - Reset overrides flush and all handshakes in the same cycle.
- Outputs are combinational from registered state plus flush. No enqueue-to-issue bypass: an entry is visible on out_* at the earliest one cycle after acceptance.
- out_valid[k] = (count > k) && !flush.
- out_data[k] = mem[(head+k) mod DEPTH].
- Issue (prefix rule): fire[0] = out_valid[0] && out_ready[0]; fire[k] = fire[k-1] && out_valid[k] && out_ready[k].
  - pops = number of fired ports.
  - out_ready[k] with fire[k-1]=0 has no effect; the entry stays.
- in_ready[j] = ((DEPTH - count) > j) && !flush. It is based on start-of-cycle occupancy only; same-cycle pops do not free space.
- Enqueue (prefix rule): acc[0] = in_valid[0] && in_ready[0]; acc[j] = acc[j-1] && in_valid[j] && in_ready[j].
  - pushes = number of accepted lanes.
  - Accepted lane j writes mem[(head+count+j) mod DEPTH].
  - A valid lane above a gap or rejected lane is dropped; the source must retry it.
- Update per edge: head <= (head+pops) mod DEPTH; count <= count + pushes - pops.
  - Simultaneous push and pop is always legal.
  - count never exceeds DEPTH and never underflows.
- Flush=1: next head=0, next count=0. No issue or enqueue handshake completes that cycle, because flush forces out_valid and in_ready low.
- Full (count=DEPTH): in_ready=0 even if ports pop that cycle.
- Empty (count=0): out_valid=0 on all ports.
- Assertions:
  - Never more than count ports fire.
  - Never more than DEPTH-count lanes accepted.
  - Order of issued data equals order of accepted data, lane 0 first within a cycle.

Test Plan:
1. Reset and fill, defaults (W=8, D=8, P=2, E=2):
   - Hold sys_rst_n=0 two cycles -> count=0, out_valid=00, in_ready=11.
   - Enqueue pairs {11,22},{33,44},{55,66},{77,88} with out_ready=00 -> count=8, in_ready=00.
   - out_data[0]=0x11, out_data[1]=0x22.
2. Prefix issue, from full:
   - out_ready=10 (port1 only) -> no pop, count stays 8.
   - out_ready=01 -> pops 0x11 only.
   - out_ready=11 -> pops 0x22, 0x33; count=5.
3. Simultaneous push/pop with wrap, from count=5, head=3:
   - Enqueue {99,AA} while popping 2 per cycle, repeated until head passes index 7.
   - Issue order stays strictly FIFO; count holds at 5.
   - Drain to empty -> out_valid=00.
4. Enqueue lane gap and partial space:
   - in_valid=10 -> nothing accepted.
   - With count=7: in_valid=11 -> in_ready=01, only lane 0 accepted; count=8.
5. Flush: with count=6 and in_valid=11, out_ready=11, flush=1:
   - Same cycle: out_valid=00, in_ready=00.
   - Next cycle: count=0; no entry from that cycle appears later.
6. Non-power-of-two and scale, D=5, P=3, E=3, W=16:
   - Random valid/ready for 2000 cycles against a scoreboard queue -> zero mismatches.
   - count always in 0..5; index wraps 4->0 exercised.
   - Mid-run sys_rst_n=0 -> empty the next cycle.
